mem_port_arbiter: RTL

Sequencer and arbiter for the single shared instruction/data memory port of the multicycle core. It serialises accesses from two requesters, the core (fetch, load and store traffic) and the external program loader, onto one memory port with a fixed read latency. It returns data and acknowledge pulses to each requester, and drives a stall to the main control FSM so that the core's access states hold until their memory access completes.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_lat_timer.sv | 38 +++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
// Optional build macro: MEM_ARB_LOADER_PRIORITY_EN (loader wins every tie).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_LD  = 1'b1
  } gnt_e;

  localparam int READ_LAT_DEF = 1;

  // Counter width able to hold READ_LAT; never below one bit.
  function automatic int cnt_width(input int lat);
    if (lat < 1) return 1;
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Loadable down-counter with a zero flag; paces the read-latency wait.
// Saturates at zero so an idle WAIT cycle never wraps.
module mem_lat_timer
  import mem_arb_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises core and loader accesses onto one fixed-latency memory port.
// Build macro MEM_ARB_LOADER_PRIORITY_EN: loader strict priority, else round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CW = cnt_width(READ_LAT);
  localparam logic [CW-1:0] LAT_M1 = CW'(READ_LAT - 1);

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  gnt_e              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_q, rd_d;

  logic pick_ld;
  logic tmr_load;
  logic tmr_dec;
  logic tmr_zero;
  logic issue;
  logic resp;

`ifdef MEM_ARB_LOADER_PRIORITY_EN
  assign pick_ld = ld_req;
`else
  // On a tie the requester not served last time goes first.
  assign pick_ld = ld_req & (~cpu_req | (last_q == GNT_CPU));
`endif

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cpu_req | ld_req) begin
          gnt_d   = pick_ld ? GNT_LD : GNT_CPU;
          last_d  = pick_ld ? GNT_LD : GNT_CPU;
          we_d    = pick_ld ? ld_we : cpu_we;
          addr_d  = pick_ld ? ld_addr : cpu_addr;
          wdata_d = pick_ld ? ld_wdata : cpu_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          tmr_load = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          rd_d    = mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= GNT_CPU;
      last_q  <= GNT_LD;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
    end
  end

  mem_lat_timer #(
    .W (CW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (LAT_M1),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  assign issue = (state_q == ISSUE);
  assign resp  = (state_q == RESP);
  assign busy  = (state_q != IDLE);

  assign mem_en    = issue;
  assign mem_we    = issue & we_q;
  assign mem_addr  = issue ? addr_q : '0;
  assign mem_wdata = issue ? wdata_q : '0;

  assign cpu_ack   = resp & (gnt_q == GNT_CPU);
  assign ld_ack    = resp & (gnt_q == GNT_LD);
  assign cpu_rdata = cpu_ack ? rd_q : '0;
  assign ld_rdata  = ld_ack ? rd_q : '0;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
